dmem_access_ctrl: RTL and testbench

- Sequences the memory-stage data access of the RV64I pipeline.
- Takes the address (alu_out_M) and store data (rs2_data_M) held in the EX/MEM pipeline register and drives a single-port data memory through a req/ack handshake.
- Stalls the pipeline while the access is outstanding.
- Returns aligned, sign/zero-extended load data, and flags misaligned accesses and bus timeouts.

---
 rtl/dmem_access_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// Module      : dmem_access_ctrl
// Description : RV64I memory-stage data access sequencer (req/ack bus, stall,
//               load extension, misalignment and timeout detection).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_access_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_M,
    input  logic        mem_read_M,
    input  logic        mem_write_M,
    input  logic [2:0]  funct3_M,
    input  logic [63:0] alu_out_M,
    input  logic [63:0] rs2_data_M,
    output logic        dm_req,
    output logic        dm_we,
    output logic [63:0] dm_addr,
    output logic [7:0]  dm_wstrb,
    output logic [63:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [63:0] dm_rdata,
    output logic        stall_M,
    output logic [63:0] ld_data_M,
    output logic        ld_valid_M,
    output logic        misalign_M,
    output logic        bus_err_M
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      addr_q;
    logic             we_q;
    logic [7:0]       wstrb_q;
    logic [63:0]      wdata_q;
    logic [2:0]       f3_q;
    logic [2:0]       off_q;
    logic             err_q;
    logic [63:0]      ld_q;

    logic             wr_d;
    logic             rd_d;
    logic             legal_d;
    logic             aligned_d;
    logic             go_d;
    logic [7:0]       strb_d;
    logic [63:0]      wdat_d;
    logic [63:0]      lane_d;
    logic [63:0]      ext_d;

    assign wr_d = mem_valid_M & mem_write_M;
    assign rd_d = mem_valid_M & mem_read_M & ~mem_write_M;

    // Stores only define sizes B..D; loads reject only funct3 = 111.
    assign legal_d = wr_d ? ~funct3_M[2] : (rd_d & (funct3_M != 3'b111));

    always_comb begin
        aligned_d = 1'b1;
        strb_d    = 8'hFF;
        wdat_d    = rs2_data_M;
        case (funct3_M[1:0])
            2'd0: begin
                strb_d = 8'h01 << alu_out_M[2:0];
                wdat_d = {8{rs2_data_M[7:0]}};
            end
            2'd1: begin
                aligned_d = ~alu_out_M[0];
                strb_d    = 8'h03 << alu_out_M[2:0];
                wdat_d    = {4{rs2_data_M[15:0]}};
            end
            2'd2: begin
                aligned_d = (alu_out_M[1:0] == 2'b00);
                strb_d    = 8'h0F << alu_out_M[2:0];
                wdat_d    = {2{rs2_data_M[31:0]}};
            end
            default: begin
                aligned_d = (alu_out_M[2:0] == 3'b000);
            end
        endcase
    end

    assign go_d = (state_q == S_IDLE) & legal_d & aligned_d;

    assign lane_d = dm_rdata >> {off_q, 3'b000};

    always_comb begin
        ext_d = lane_d;
        case (f3_q)
            3'b000:  ext_d = {{56{lane_d[7]}},  lane_d[7:0]};
            3'b001:  ext_d = {{48{lane_d[15]}}, lane_d[15:0]};
            3'b010:  ext_d = {{32{lane_d[31]}}, lane_d[31:0]};
            3'b100:  ext_d = {56'd0, lane_d[7:0]};
            3'b101:  ext_d = {48'd0, lane_d[15:0]};
            3'b110:  ext_d = {32'd0, lane_d[31:0]};
            default: ext_d = lane_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            err_q   <= 1'b0;
            ld_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go_d) begin
                        addr_q  <= {alu_out_M[63:3], 3'b000};
                        we_q    <= wr_d;
                        wstrb_q <= wr_d ? strb_d : 8'h00;
                        wdata_q <= wdat_d;
                        f3_q    <= funct3_M;
                        off_q   <= alu_out_M[2:0];
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dm_ack) begin
                        if (!we_q) begin
                            ld_q <= ext_d;
                        end
                        state_q <= S_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // Always return to IDLE so the held instruction is not reissued.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dm_req     = (state_q == S_REQ);
    assign dm_we      = we_q;
    assign dm_addr    = addr_q;
    assign dm_wstrb   = wstrb_q;
    assign dm_wdata   = wdata_q;
    assign stall_M    = go_d | (state_q == S_REQ);
    assign ld_data_M  = ld_q;
    assign ld_valid_M = (state_q == S_DONE) & ~err_q & ~we_q;
    assign bus_err_M  = (state_q == S_DONE) & err_q;
    assign misalign_M = (state_q == S_IDLE) & legal_d & ~aligned_d;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// Module      : tb_dmem_access_ctrl
// Description : Self-checking bench for dmem_access_ctrl with a byte-level
//               reference model and a delayed-ack memory responder.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_access_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid_M = 1'b0;
    logic        mem_read_M = 1'b0;
    logic        mem_write_M = 1'b0;
    logic [2:0]  funct3_M = 3'd0;
    logic [63:0] alu_out_M = 64'd0;
    logic [63:0] rs2_data_M = 64'd0;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [7:0]  dm_wstrb;
    logic [63:0] dm_wdata;
    logic        dm_ack = 1'b0;
    logic [63:0] dm_rdata = 64'd0;
    logic        stall_M;
    logic [63:0] ld_data_M;
    logic        ld_valid_M;
    logic        misalign_M;
    logic        bus_err_M;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_ld = 64'd0;

    dmem_access_ctrl #(.TIMEOUT_CYC(T), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_M(mem_valid_M), .mem_read_M(mem_read_M), .mem_write_M(mem_write_M),
        .funct3_M(funct3_M), .alu_out_M(alu_out_M), .rs2_data_M(rs2_data_M),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall_M(stall_M), .ld_data_M(ld_data_M), .ld_valid_M(ld_valid_M),
        .misalign_M(misalign_M), .bus_err_M(bus_err_M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pick nb bytes starting at byte offset a, then sign- or zero-fill the rest.
    function automatic logic [63:0] model_load(input logic [2:0] f3, input int a,
                                               input logic [63:0] rdata);
        int          nb = 1 << f3[1:0];
        logic [63:0] v  = 64'd0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = rdata[8*(a+k) +: 8];
        if (!f3[2] && v[8*nb-1])
            for (int k = nb; k < 8; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic clear_inputs();
        mem_valid_M = 1'b0;
        mem_read_M  = 1'b0;
        mem_write_M = 1'b0;
    endtask

    // Issue one M-stage instruction; delay = REQ cycles without ack before the ack.
    task automatic access(input bit v, input bit wr, input bit rd, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input logic [63:0] rdat, input int delay);
        int          nb = 1 << f3[1:0];
        int          a  = int'(addr[2:0]);
        bit          is_wr = v && wr;
        bit          is_rd = v && rd && !wr;
        bit          legal = is_wr ? (f3 < 3'd4) : (is_rd ? (f3 != 3'd7) : 1'b0);
        bit          aligned = (a % nb) == 0;
        bit          go = legal && aligned;
        bit          timed = delay >= T;
        int          exp_reqs = timed ? T : delay + 1;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wd;
        logic [63:0] prev_addr = dm_addr;
        int          reqs = 0;
        int          stalls = 1;
        bit          done = 1'b0;

        exp_strb = is_wr ? 8'(((1 << nb) - 1) << a) : 8'h00;
        for (int i = 0; i < 8; i++) exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];

        mem_valid_M = v;
        mem_write_M = wr;
        mem_read_M  = rd;
        funct3_M    = f3;
        alu_out_M   = addr;
        rs2_data_M  = wd;
        dm_rdata    = rdat;
        #1;
        chk("misalign", 64'(misalign_M), 64'(legal && !aligned));
        chk("accept_stall", 64'(stall_M), 64'(go));
        if (!go) begin
            @(posedge clk); #1;
            chk("noreq", 64'(dm_req), 64'd0);
            chk("addr_unchanged", dm_addr, prev_addr);
            chk("noreq_ldvalid", 64'(ld_valid_M), 64'd0);
            clear_inputs();
        end else begin
            for (int c = 0; c < 40 && !done; c++) begin
                @(posedge clk); #1;
                if (dm_req) begin
                    if (reqs == 0) begin
                        chk("dm_addr", dm_addr, {addr[63:3], 3'b000});
                        chk("dm_we", 64'(dm_we), 64'(is_wr));
                        chk("dm_wstrb", 64'(dm_wstrb), 64'(exp_strb));
                        if (is_wr) chk("dm_wdata", dm_wdata, exp_wd);
                    end
                    stalls += int'(stall_M);
                    dm_ack = (reqs == delay);
                    reqs++;
                end else begin
                    dm_ack = 1'b0;
                    done   = 1'b1;
                    chk("done_stall", 64'(stall_M), 64'd0);
                    chk("bus_err", 64'(bus_err_M), 64'(timed));
                    chk("ld_valid", 64'(ld_valid_M), 64'(is_rd && !timed));
                    if (is_rd && !timed) exp_ld = model_load(f3, a, rdat);
                    chk("ld_data", ld_data_M, exp_ld);
                    clear_inputs();
                end
            end
            if (!done) chk("done_reached", 64'd0, 64'd1);
            chk("req_cycles", 64'(reqs), 64'(exp_reqs));
            chk("stall_cycles", 64'(stalls), 64'(exp_reqs + 1));
        end
        @(posedge clk); #1;
        chk("idle_ldvalid", 64'(ld_valid_M), 64'd0);
        chk("idle_buserr", 64'(bus_err_M), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 64'(dm_req), 64'd0);
        chk("rst_we", 64'(dm_we), 64'd0);
        chk("rst_wstrb", 64'(dm_wstrb), 64'd0);
        chk("rst_addr", dm_addr, 64'd0);
        chk("rst_wdata", dm_wdata, 64'd0);
        chk("rst_ld", ld_data_M, 64'd0);
        chk("rst_ldvalid", 64'(ld_valid_M), 64'd0);
        chk("rst_buserr", 64'(bus_err_M), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        access(1, 0, 1, 3'b011, 64'h1000, 64'd0, 64'h8877665544332211, 0);
        chk("ld_const", ld_data_M, 64'h8877665544332211);
        access(1, 0, 1, 3'b000, 64'h2007, 64'd0, 64'h8011223344556677, 1);
        chk("lb_const", ld_data_M, 64'hFFFFFFFFFFFFFF80);
        access(1, 0, 1, 3'b100, 64'h2007, 64'd0, 64'h8011223344556677, 0);
        chk("lbu_const", ld_data_M, 64'h0000000000000080);
        access(1, 1, 0, 3'b001, 64'h3002, 64'h1234ABCD, 64'd0, 3);
        access(1, 0, 1, 3'b010, 64'h4002, 64'd0, 64'd0, 0);
        access(1, 1, 0, 3'b011, 64'h4008, 64'h0123456789ABCDEF, 64'd0, 2);
        access(1, 0, 1, 3'b011, 64'h5000, 64'd0, 64'hDEADBEEFCAFEF00D, 100);
        chk("timeout_ld_kept", ld_data_M, 64'h0000000000000080);
        access(1, 0, 0, 3'b011, 64'h6000, 64'd0, 64'd0, 0);
        access(1, 0, 1, 3'b111, 64'h6000, 64'd0, 64'd0, 0);
        access(1, 1, 0, 3'b100, 64'h6000, 64'hFF, 64'd0, 0);
        access(0, 1, 1, 3'b000, 64'h6000, 64'hFF, 64'd0, 0);

        // An ack with no request outstanding must have no effect.
        dm_ack = 1'b1;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("stray_ack_req", 64'(dm_req), 64'd0);
        chk("stray_ack_ldvalid", 64'(ld_valid_M), 64'd0);

        for (int n = 0; n < 60; n++) begin
            access(1, 1'($urandom), 1'($urandom), 3'($urandom),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(0, 5)));
        end

        // Reset arriving in the second REQ cycle aborts the access.
        mem_valid_M = 1'b1;
        mem_read_M  = 1'b1;
        funct3_M    = 3'b011;
        alu_out_M   = 64'h7000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_req", 64'(dm_req), 64'd1);
        rst = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        rst    = 1'b1;
        exp_ld = 64'd0;
        chk("mid_rst_req", 64'(dm_req), 64'd0);
        chk("mid_rst_stall", 64'(stall_M), 64'd0);
        chk("mid_rst_ld", ld_data_M, exp_ld);
        dm_ack = 1'b1;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("late_ack_req", 64'(dm_req), 64'd0);
        chk("late_ack_ldvalid", 64'(ld_valid_M), 64'd0);
        @(posedge clk); #1;
        chk("late_ack_ldvalid2", 64'(ld_valid_M), 64'd0);
        chk("late_ack_buserr", 64'(bus_err_M), 64'd0);
        chk("late_ack_stall", 64'(stall_M), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
